// File: rtl/alu_uart_iface.sv
// alu_uart_iface: collects A, B and opcode bytes from uart_rx, drives the ALU, sends the result byte to uart_tx.
// Optional opcode validation with ERR_CODE reply is enabled by defining ALU_IFACE_OPCHECK_EN.
module alu_uart_iface #(
    parameter int                 NB_DATA   = 8,
    parameter int                 NB_OPCODE = 6,
    parameter logic [NB_DATA-1:0] ERR_CODE  = 8'hEE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_op_1,
    output logic [NB_DATA-1:0]   o_op_2,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_overrun,
    output logic [2:0]           o_state
);
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        COMPUTE = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   op_1_q, op_1_d, op_2_q, op_2_d, tx_data_q, tx_data_d;
    logic [NB_OPCODE-1:0] opcode_q, opcode_d;
    logic                 tx_start_q, tx_start_d, overrun_q, overrun_d;
    logic                 accepting;

`ifdef ALU_IFACE_OPCHECK_EN
    logic                 op_ok;
    assign op_ok = (i_rx_data[NB_DATA-1:NB_OPCODE] == '0) &&
                   (i_rx_data[NB_OPCODE-1:0] inside {NB_OPCODE'('h20), NB_OPCODE'('h22), NB_OPCODE'('h24),
                                                      NB_OPCODE'('h25), NB_OPCODE'('h26), NB_OPCODE'('h03),
                                                      NB_OPCODE'('h02), NB_OPCODE'('h27)});
`endif

    // Only the three collection states take bytes; anything else, including illegal codes, is an overrun.
    assign accepting = (state_q == WAIT_A) || (state_q == WAIT_B) || (state_q == WAIT_OP);

    always_comb begin
        state_d    = state_q;
        op_1_d     = op_1_q;
        op_2_d     = op_2_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = overrun_q | (i_rx_done & ~accepting);
        case (state_q)
            WAIT_A: if (i_rx_done) begin
                op_1_d  = i_rx_data;
                state_d = WAIT_B;
            end
            WAIT_B: if (i_rx_done) begin
                op_2_d  = i_rx_data;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (i_rx_done) begin
`ifdef ALU_IFACE_OPCHECK_EN
                if (op_ok) begin
                    opcode_d = i_rx_data[NB_OPCODE-1:0];
                    state_d  = COMPUTE;
                end else begin
                    tx_data_d = ERR_CODE;
                    state_d   = SEND;
                end
`else
                opcode_d = i_rx_data[NB_OPCODE-1:0];
                state_d  = COMPUTE;
`endif
            end
            COMPUTE: begin
                tx_data_d = i_alu_result;
                state_d   = SEND;
            end
            SEND: if (!i_tx_busy) begin
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: if (i_tx_done) state_d = WAIT_A;
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            op_1_q     <= '0;
            op_2_q     <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_1_q     <= op_1_d;
            op_2_q     <= op_2_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_op_1     = op_1_q;
    assign o_op_2     = op_2_q;
    assign o_opcode   = opcode_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_overrun  = overrun_q;
    assign o_state    = state_q;
endmodule

// File: tb/tb_alu_uart_iface.sv
// tb_alu_uart_iface: directed bench with a behavioural ALU and a scoreboard of expected TX bytes.
module tb_alu_uart_iface;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_res;
    logic [7:0] op_1, op_2, tx_data;
    logic [5:0] opcode;
    logic       tx_start, overrun;
    logic [2:0] state;

    int         checks = 0;
    int         failures = 0;
    int         pulses = 0;
    int         k;
    logic [7:0] exp_q[$];

    alu_uart_iface dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_busy(tx_busy), .i_tx_done(tx_done), .i_alu_result(alu_res),
        .o_op_1(op_1), .o_op_2(op_2), .o_opcode(opcode), .o_tx_data(tx_data),
        .o_tx_start(tx_start), .o_overrun(overrun), .o_state(state)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_res = 8'h00;
        case (opcode)
            6'h20: alu_res = op_1 + op_2;
            6'h22: alu_res = op_1 - op_2;
            6'h24: alu_res = op_1 & op_2;
            6'h25: alu_res = op_1 | op_2;
            6'h26: alu_res = op_1 ^ op_2;
            6'h03: alu_res = $signed(op_1) >>> op_2;
            6'h02: alu_res = op_1 >> op_2;
            6'h27: alu_res = ~(op_1 | op_2);
            default: alu_res = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) chk("tx_unexpected", exp_q.size(), 1);
            else chk("tx_data", tx_data, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("tx_start_timeout", n, 0);
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] exp, input int lat);
        int n;
        exp_q.push_back(exp);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_start(n);
        chk("latency", n, lat);
        done_pulse();
        chk("state_after_done", state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_op1", op_1, 0);
        chk("rst_op2", op_2, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_txstart", tx_start, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_cmd(8'h05, 8'h03, 8'h20, 8'h08, 2);
        chk("cmd1_op1", op_1, 8'h05);
        chk("cmd1_op2", op_2, 8'h03);
        chk("cmd1_opcode", opcode, 6'h20);
        chk("cmd1_pulses", pulses, 1);

        do_cmd(8'hF0, 8'h02, 8'h03, 8'hFC, 2);
        do_cmd(8'h0F, 8'h0F, 8'h27, 8'hF0, 2);
        chk("b2b_pulses", pulses, 3);

        tx_busy = 1'b1;
        exp_q.push_back(8'h0C);
        send_byte(8'h07);
        send_byte(8'h05);
        send_byte(8'h20);
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("busy_state", state, 4);
        chk("busy_no_start", tx_start, 0);
        chk("busy_pulses", pulses, 3);
        tx_busy = 1'b0;
        @(posedge clk); #1;
        chk("busy_release_start", tx_start, 1);
        done_pulse();
        chk("busy_single_pulse", pulses, 4);

        chk("overrun_clear", overrun, 0);
        exp_q.push_back(8'h02);
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h24);
        wait_start(k);
        send_byte(8'hAA);
        chk("ovr_state", state, 5);
        chk("ovr_flag", overrun, 1);
        chk("ovr_op1", op_1, 8'h07);
        chk("ovr_op2", op_2, 8'h02);
        chk("ovr_opcode", opcode, 6'h24);
        done_pulse();
        chk("ovr_state_done", state, 0);
        do_cmd(8'h01, 8'h01, 8'h22, 8'h00, 2);
        chk("ovr_sticky", overrun, 1);

        exp_q.push_back(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h25);
        wait_start(k);
        rx_data = 8'h55;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        chk("simul_state", state, 0);
        chk("simul_op1", op_1, 8'h01);

        send_byte(8'h11);
        send_byte(8'h22);
        chk("mid_state", state, 2);
        rst = 1'b1;
        #1;
        chk("async_state", state, 0);
        chk("async_op1", op_1, 0);
        chk("async_op2", op_2, 0);
        chk("async_opcode", opcode, 0);
        chk("async_txdata", tx_data, 0);
        chk("async_overrun", overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_cmd(8'h09, 8'h04, 8'h22, 8'h05, 2);
        chk("post_rst_op1", op_1, 8'h09);

`ifdef ALU_IFACE_OPCHECK_EN
        do_cmd(8'h02, 8'h03, 8'h3F, 8'hEE, 1);
        chk("opchk_3f_opcode", opcode, 6'h22);
        do_cmd(8'h0F, 8'h3C, 8'hE4, 8'hEE, 1);
        chk("opchk_e4_opcode", opcode, 6'h22);
`else
        do_cmd(8'h02, 8'h03, 8'h3F, 8'h00, 2);
        chk("noopchk_3f_opcode", opcode, 6'h3F);
        do_cmd(8'h0F, 8'h3C, 8'hE4, 8'h0C, 2);
        chk("noopchk_e4_opcode", opcode, 6'h24);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("total_pulses", pulses, 10);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_uart_iface.md
Name: alu_uart_iface

Overview:
- Sequencer on the host side of the ALU. It collects operand A, operand B and the opcode as three bytes from a UART receiver.
- It drives the ALU operand and opcode inputs, samples the combinational ALU result, and hands that result to a UART transmitter as one byte.
- It sits between uart_rx/uart_tx and alu in the Basys3 top level. It replaces switch/button operand loading.

Parameters:
- NB_DATA, 8, width of operands, result, and UART byte.
- NB_OPCODE, 6, width of the ALU opcode.
- ERR_CODE, 8'hEE, byte sent when an opcode is rejected (feature only).

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  reset, asynchronous and active-high.
- i_rx_data  in  NB_DATA  received byte; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse from uart_rx: byte available.
- i_tx_busy  in  1  uart_tx is shifting a frame.
- i_tx_done  in  1  one-cycle pulse from uart_tx: frame finished.
- i_alu_result  in  NB_DATA  alu o_result (combinational).
- o_op_1  out  NB_DATA  latched operand A to alu i_op_1.
- o_op_2  out  NB_DATA  latched operand B to alu i_op_2.
- o_opcode  out  NB_OPCODE  latched opcode to alu i_opcode.
- o_tx_data  out  NB_DATA  byte for uart_tx; held from tx_start until tx_done.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_overrun  out  1  sticky: an rx byte arrived while not accepting.
- o_state  out  3  current FSM state encoding, for LEDs.

Behaviour:
- Reset (async, i_reset=1) clears the following immediately, also mid-transaction:
  - state to WAIT_A;
  - o_op_1, o_op_2, o_opcode, o_tx_data to 0;
  - o_tx_start and o_overrun to 0.
- A partially received command is discarded on reset.
- State encoding: WAIT_A=0, WAIT_B=1, WAIT_OP=2, COMPUTE=3, SEND=4, WAIT_TX=5. Codes 6 and 7 are illegal and go to WAIT_A on the next clock.
- WAIT_A: on i_rx_done, o_op_1 <= i_rx_data, then go to WAIT_B.
- WAIT_B: on i_rx_done, o_op_2 <= i_rx_data, then go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_opcode <= i_rx_data[NB_OPCODE-1:0] (upper bits ignored), then go to COMPUTE.
- COMPUTE: lasts exactly 1 cycle, giving the ALU a full cycle to settle. On the exit edge, o_tx_data <= i_alu_result, then go to SEND.
- SEND:
  - if i_tx_busy=0: o_tx_start=1 for exactly one cycle, then go to WAIT_TX;
  - if i_tx_busy=1: stay in SEND with o_tx_start=0.
- WAIT_TX: stay until i_tx_done, then go to WAIT_A.
- o_op_1, o_op_2, o_opcode hold their values until overwritten by the next command. The ALU output therefore stays stable after a transaction.
- o_tx_start is registered and is never high in any state other than the cycle leaving SEND.
- Latency: the opcode byte's i_rx_done edge is followed by COMPUTE, then SEND. o_tx_start is high on the 2nd cycle after that edge when the TX is idle.
- i_rx_done in COMPUTE, SEND or WAIT_TX:
  - the byte is dropped;
  - o_overrun <= 1, and it stays set until reset;
  - the state is unaffected.
- i_tx_done outside WAIT_TX is ignored.
- Simultaneous i_rx_done and i_tx_done in WAIT_TX: go to WAIT_A, drop the byte, set o_overrun.
- Only state codes 0–2 accept rx bytes.

Optional Feature:
- Macro ALU_IFACE_OPCHECK_EN.
- Defined:
  - in WAIT_OP, the byte is accepted only if bits [NB_DATA-1:NB_OPCODE] are 0 and the low bits are one of 0x20, 0x22, 0x24, 0x25, 0x26, 0x03, 0x02, 0x27;
  - an invalid byte leaves o_opcode unchanged, loads o_tx_data <= ERR_CODE, and goes directly to SEND, skipping COMPUTE.
- Not defined: no checking; the low NB_OPCODE bits are always used.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 with an alu instance and tx_busy=0 -> o_op_1=0x05, o_op_2=0x03, o_opcode=0x20; one tx_start pulse 2 cycles after the third rx_done with o_tx_data=0x08; state returns to 0 after tx_done.
- Bytes 0xF0, 0x02, 0x03 (SRA) -> o_tx_data=0xFC. Then 0x0F, 0x0F, 0x27 (NOR) -> o_tx_data=0xF0. The two commands run back-to-back with no gap.
- Hold i_tx_busy=1 for 20 cycles at SEND -> o_tx_start stays 0; a single pulse follows the cycle after busy drops.
- Send an extra byte 0xAA during WAIT_TX -> o_overrun=1; operands unchanged; the next command 0x01, 0x01, 0x22 -> result 0x00.
- Assert i_reset after A and B only -> outputs 0, state 0; a new A/B/op triple is processed correctly.
- With ALU_IFACE_OPCHECK_EN: opcode byte 0x3F -> o_tx_data=0xEE, o_opcode unchanged. Without the macro: the same byte gives o_opcode=0x3F.
